multicycle_main_control: RTL and testbench
==========================================

# multicycle_main_control

Multi-cycle control FSM for the integer core, succeeding the combinational main decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives a shared instruction/data memory through a request/acknowledge handshake with a parametrised timeout. It holds undefined-instruction and memory-timeout faults as sticky traps and counts retired instructions. It sits between the instruction register/opcode field and the datapath enables.

## Interface
- MEM_TIMEOUT, 16: maximum wait cycles for Mem_Ack per request; 0 disables timeout
- CNT_W, 32: width of retired-instruction counter
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- EN_PC  in  1  advance enable; low = stall
- Opcode  in  7  instruction[6:0] from IR
- Branch_Taken  in  1  branch comparator result, valid in EXECUTE
- Mem_Ack  in  1  memory completes current request this cycle
- Trap_Clr  in  1  leave TRAP
- Mem_Req  out  1  memory request
- IR_Wr_En  out  1  load IR
- PC_Wr_En  out  1  load PC
- MEM_Wr_En  out  1  request is a write
- Reg_Wr_En  out  1  register file write
- Src_to_Reg  out  2  00 ALU, 01 memory, 10 PC+4
- ALU_Src1_Sel, ALU_Src2_Sel  out  1 each  ALU operand selects
- Branch, Jump  out  1 each  PC source qualifiers
- undef_instr, Mem_Timeout  out  1 each  sticky fault flags
- Instr_Done  out  1  one-cycle retire pulse
- Instr_Cnt  out  CNT_W  retired-instruction count
- State  out  3  current state encoding

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=7.
- IDLE: all outputs 0. Goes to FETCH on EN_PC.
- FETCH: Mem_Req=1, MEM_Wr_En=0. On Mem_Ack: IR_Wr_En=1 and PC_Wr_En=1 (PC+4), then go to DECODE.
- DECODE: latches Opcode into Opc_q.
  - Supported opcodes: R_TYPE 0110011, IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. These go to EXECUTE.
  - Any other opcode: go to TRAP and set undef_instr.
- EXECUTE, operand selects {Src1,Src2} by Opc_q:
  - R_TYPE: 00
  - IMM, LOAD, STORE, LUI, JALR: 01
  - BRANCH, JAL, AUIPC: 11
- EXECUTE next state:
  - R_TYPE, IMM, LUI, AUIPC, JAL, JALR: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: Branch=1, PC_Wr_En=Branch_Taken, then go to FETCH (retire).
- MEM: Mem_Req=1, MEM_Wr_En=1 for STORE. On Mem_Ack: LOAD goes to WB; STORE goes to FETCH (retire).
- WB: Reg_Wr_En=1. Src_to_Reg is 01 for LOAD, 10 for JAL/JALR, 00 otherwise. JAL/JALR also drive Jump=1 and PC_Wr_En=1 with the EXECUTE-state operand selects. Then go to FETCH (retire).
- Retire: Instr_Done=1 for the transition cycle; Instr_Cnt increments and wraps at 2^CNT_W.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle with Mem_Req=1 and Mem_Ack=0.
  - When MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 without ack: go to TRAP and set Mem_Timeout.
  - An ack on that same cycle wins.
- TRAP: all enables and Mem_Req are 0. Flags are held. Trap_Clr=1 clears both flags and goes to IDLE.
- EN_PC=0 in any state:
  - State, Opc_q and the wait counter hold.
  - Mem_Req, IR_Wr_En, PC_Wr_En, MEM_Wr_En, Reg_Wr_En, Instr_Done are forced 0.
  - Mem_Ack is ignored.
  - Select outputs (Src_to_Reg, ALU selects, Branch, Jump) keep their state values.
  - TRAP still honours Trap_Clr.

## Timing
- Reset (asynchronous): State=IDLE, Opc_q=0, wait counter 0, Instr_Cnt 0, both flags 0, all outputs 0. Assertion mid-instruction aborts it immediately.
- State, flags, counters and Opc_q are registered. All other outputs are combinational from state, Opc_q, EN_PC, Mem_Ack and Branch_Taken.
- Latency with zero-wait memory (ack in the first request cycle):
  - R/IMM/LUI/AUIPC/JAL/JALR: 4 cycles FETCH→FETCH
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
  - Each wait cycle adds 1.
- Mem_Ack seen in cycle n moves the state at edge n+1. The request is dropped the cycle after the ack.

## Test plan
- Reset, EN_PC=1, R_TYPE, Mem_Ack immediate → State 0,1,2,3,5,1. Reg_Wr_En high in WB only. Instr_Cnt=1, Instr_Done one cycle.
- LOAD with Mem_Ack delayed 2 cycles in MEM → MEM lasts 3 cycles, MEM_Wr_En=0, WB Src_to_Reg=01. 7-cycle instruction.
- BRANCH with Branch_Taken=1, then again with 0 → PC_Wr_En in EXECUTE 1 then 0. {Src1,Src2}=11, 3 cycles each.
- Opcode 1111111 → TRAP at DECODE+1, undef_instr=1 held 10 cycles. Trap_Clr → IDLE, flag 0.
- MEM_TIMEOUT=4, no Mem_Ack in FETCH → TRAP after 4 request cycles, Mem_Timeout=1. Ack exactly on the 4th cycle → DECODE instead.
- STORE with EN_PC=0 for 3 cycles inside MEM, then RST asserted mid-LOAD → enables 0 and state held during stall, then single write. RST gives IDLE and Instr_Cnt=0 in the same cycle.

Source files
------------

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: multi-cycle fetch/decode/execute/mem/wb sequencer with a shared-memory
// request/ack handshake, wait timeout, sticky fault traps and a retired-instruction counter.
module multicycle_main_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN_PC,
    input  logic [6:0]       Opcode,
    input  logic             Branch_Taken,
    input  logic             Mem_Ack,
    input  logic             Trap_Clr,
    output logic             Mem_Req,
    output logic             IR_Wr_En,
    output logic             PC_Wr_En,
    output logic             MEM_Wr_En,
    output logic             Reg_Wr_En,
    output logic [1:0]       Src_to_Reg,
    output logic             ALU_Src1_Sel,
    output logic             ALU_Src2_Sel,
    output logic             Branch,
    output logic             Jump,
    output logic             undef_instr,
    output logic             Mem_Timeout,
    output logic             Instr_Done,
    output logic [CNT_W-1:0] Instr_Cnt,
    output logic [2:0]       State
);
    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_TIMEOUT - 1);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7
    } state_t;

    state_t           r_state, w_next;
    logic [6:0]       r_opc;
    logic [WW-1:0]    r_wait;
    logic [CNT_W-1:0] r_cnt;
    logic             r_undef, r_tmo;
    logic             w_ld, w_st, w_br, w_jmp, w_known, w_req, w_tmo_hit, w_done;
    logic [1:0]       w_sel;

    assign w_ld    = r_opc == OP_LOAD;
    assign w_st    = r_opc == OP_STORE;
    assign w_br    = r_opc == OP_BR;
    assign w_jmp   = r_opc == OP_JAL || r_opc == OP_JALR;
    assign w_known = Opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    assign w_sel   = r_opc == OP_R ? 2'b00 : (w_br || r_opc == OP_JAL || r_opc == OP_AUIPC) ? 2'b11 : 2'b01;
    assign w_req   = EN_PC && (r_state == S_FETCH || r_state == S_MEM);
    // an ack arriving on the final allowed wait cycle takes priority over the timeout
    assign w_tmo_hit = MEM_TIMEOUT != 0 && r_wait == LAST_WAIT && !Mem_Ack;
    assign w_done  = EN_PC && ((r_state == S_EXEC && w_br) || (r_state == S_MEM && Mem_Ack && w_st) || r_state == S_WB);

    always_comb begin
        w_next = r_state;
        if (r_state == S_TRAP)
            w_next = Trap_Clr ? S_IDLE : S_TRAP;
        else if (EN_PC)
            case (r_state)
                S_IDLE:   w_next = S_FETCH;
                S_FETCH:  w_next = Mem_Ack ? S_DECODE : w_tmo_hit ? S_TRAP : S_FETCH;
                S_DECODE: w_next = w_known ? S_EXEC : S_TRAP;
                S_EXEC:   w_next = w_br ? S_FETCH : (w_ld || w_st) ? S_MEM : S_WB;
                S_MEM:    w_next = Mem_Ack ? (w_ld ? S_WB : S_FETCH) : w_tmo_hit ? S_TRAP : S_MEM;
                S_WB:     w_next = S_FETCH;
                default:  w_next = S_IDLE;
            endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_opc   <= '0;
            r_wait  <= '0;
            r_cnt   <= '0;
            r_undef <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (EN_PC && r_state == S_DECODE)
                r_opc <= Opcode;
            if (w_next != r_state && (w_next == S_FETCH || w_next == S_MEM))
                r_wait <= '0;
            else if (w_req && !Mem_Ack)
                r_wait <= r_wait + 1'b1;
            if (r_state == S_TRAP && Trap_Clr) begin
                r_undef <= 1'b0;
                r_tmo   <= 1'b0;
            end else begin
                r_undef <= r_undef | (EN_PC && r_state == S_DECODE && !w_known);
                r_tmo   <= r_tmo | (w_req && w_tmo_hit);
            end
            if (w_done)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign State        = r_state;
    assign Mem_Req      = w_req;
    assign IR_Wr_En     = EN_PC && r_state == S_FETCH && Mem_Ack;
    assign PC_Wr_En     = IR_Wr_En || (EN_PC && ((r_state == S_EXEC && w_br && Branch_Taken) || (r_state == S_WB && w_jmp)));
    assign MEM_Wr_En    = w_req && r_state == S_MEM && w_st;
    assign Reg_Wr_En    = EN_PC && r_state == S_WB;
    assign Src_to_Reg   = r_state != S_WB ? 2'b00 : w_ld ? 2'b01 : w_jmp ? 2'b10 : 2'b00;
    assign {ALU_Src1_Sel, ALU_Src2_Sel} = (r_state == S_EXEC || (r_state == S_WB && w_jmp)) ? w_sel : 2'b00;
    assign Branch       = r_state == S_EXEC && w_br;
    assign Jump         = r_state == S_WB && w_jmp;
    assign undef_instr  = r_undef;
    assign Mem_Timeout  = r_tmo;
    assign Instr_Done   = w_done;
    assign Instr_Cnt    = r_cnt;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: directed per-cycle vectors queued by the driver and checked by a negedge monitor.
module tb_multicycle_main_control;
    localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, BAD = 7'b1111111;

    logic        CLK = 1'b0, RST = 1'b1, EN_PC = 1'b0, Branch_Taken = 1'b0, Mem_Ack = 1'b0, Trap_Clr = 1'b0;
    logic [6:0]  Opcode = 7'd0;
    logic        Mem_Req, IR_Wr_En, PC_Wr_En, MEM_Wr_En, Reg_Wr_En, ALU_Src1_Sel, ALU_Src2_Sel;
    logic        Branch, Jump, undef_instr, Mem_Timeout, Instr_Done;
    logic [1:0]  Src_to_Reg;
    logic [31:0] Instr_Cnt;
    logic [2:0]  State;

    typedef struct {
        string       nm;
        logic [48:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;

    multicycle_main_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .EN_PC(EN_PC), .Opcode(Opcode), .Branch_Taken(Branch_Taken),
        .Mem_Ack(Mem_Ack), .Trap_Clr(Trap_Clr), .Mem_Req(Mem_Req), .IR_Wr_En(IR_Wr_En),
        .PC_Wr_En(PC_Wr_En), .MEM_Wr_En(MEM_Wr_En), .Reg_Wr_En(Reg_Wr_En), .Src_to_Reg(Src_to_Reg),
        .ALU_Src1_Sel(ALU_Src1_Sel), .ALU_Src2_Sel(ALU_Src2_Sel), .Branch(Branch), .Jump(Jump),
        .undef_instr(undef_instr), .Mem_Timeout(Mem_Timeout), .Instr_Done(Instr_Done),
        .Instr_Cnt(Instr_Cnt), .State(State)
    );

    always #5 CLK = ~CLK;

    // ctl = {Mem_Req,IR,PC,MEM_Wr,Reg_Wr}; sel = {Src_to_Reg,Src1,Src2,Branch,Jump}; fl = {undef,tmo,done}
    task automatic cyc(input string nm, input logic rst, en, input logic [6:0] opc, input logic ack, bt, clr,
                       input logic [2:0] st, input logic [4:0] ctl, input logic [5:0] sel,
                       input logic [2:0] fl, input logic [31:0] cnt);
        exp_t x;
        RST = rst; EN_PC = en; Opcode = opc; Mem_Ack = ack; Branch_Taken = bt; Trap_Clr = clr;
        x.nm = nm;
        x.v = {st, ctl, sel, fl, cnt};
        q.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (q.size() != 0) begin
            logic [48:0] got;
            e = q.pop_front();
            got = {State, Mem_Req, IR_Wr_En, PC_Wr_En, MEM_Wr_En, Reg_Wr_En, Src_to_Reg,
                   ALU_Src1_Sel, ALU_Src2_Sel, Branch, Jump, undef_instr, Mem_Timeout, Instr_Done, Instr_Cnt};
            n_chk++;
            if (got === e.v) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.nm, got, e.v);
        end
    end

    initial begin
        @(posedge CLK);
        #1;
        cyc("reset",    1, 0, R, 0, 0, 0, 3'd0, 5'b00000, 6'b000000, 3'b000, 0);
        cyc("idle",     0, 1, R, 0, 0, 0, 3'd0, 5'b00000, 6'b000000, 3'b000, 0);
        cyc("r_fetch",  0, 1, R, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 0);
        cyc("r_dec",    0, 1, R, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 0);
        cyc("r_exe",    0, 1, R, 0, 0, 0, 3'd3, 5'b00000, 6'b000000, 3'b000, 0);
        cyc("r_wb",     0, 1, R, 0, 0, 0, 3'd5, 5'b00001, 6'b000000, 3'b001, 0);
        cyc("ld_fetch", 0, 1, LD, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 1);
        cyc("ld_dec",   0, 1, LD, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 1);
        cyc("ld_exe",   0, 1, LD, 0, 0, 0, 3'd3, 5'b00000, 6'b000100, 3'b000, 1);
        cyc("ld_mem0",  0, 1, LD, 0, 0, 0, 3'd4, 5'b10000, 6'b000000, 3'b000, 1);
        cyc("ld_mem1",  0, 1, LD, 0, 0, 0, 3'd4, 5'b10000, 6'b000000, 3'b000, 1);
        cyc("ld_mem2",  0, 1, LD, 1, 0, 0, 3'd4, 5'b10000, 6'b000000, 3'b000, 1);
        cyc("ld_wb",    0, 1, LD, 0, 0, 0, 3'd5, 5'b00001, 6'b010000, 3'b001, 1);
        cyc("bt_fetch", 0, 1, BR, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 2);
        cyc("bt_dec",   0, 1, BR, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 2);
        cyc("bt_exe",   0, 1, BR, 0, 1, 0, 3'd3, 5'b00100, 6'b001110, 3'b001, 2);
        cyc("bn_fetch", 0, 1, BR, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 3);
        cyc("bn_dec",   0, 1, BR, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 3);
        cyc("bn_exe",   0, 1, BR, 0, 0, 0, 3'd3, 5'b00000, 6'b001110, 3'b001, 3);
        cyc("jal_fetch",0, 1, JAL, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 4);
        cyc("jal_dec",  0, 1, JAL, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 4);
        cyc("jal_exe",  0, 1, JAL, 0, 0, 0, 3'd3, 5'b00000, 6'b001100, 3'b000, 4);
        cyc("jal_wb",   0, 1, JAL, 0, 0, 0, 3'd5, 5'b00101, 6'b101101, 3'b001, 4);
        cyc("ud_fetch", 0, 1, BAD, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 5);
        cyc("ud_dec",   0, 1, BAD, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 5);
        for (int i = 0; i < 10; i++)
            cyc("ud_trap_hold", 0, 1, BAD, 1, 0, 0, 3'd7, 5'b00000, 6'b000000, 3'b100, 5);
        cyc("ud_clr",   0, 1, R, 0, 0, 1, 3'd7, 5'b00000, 6'b000000, 3'b100, 5);
        cyc("ud_idle",  0, 1, R, 0, 0, 0, 3'd0, 5'b00000, 6'b000000, 3'b000, 5);
        for (int i = 0; i < 4; i++)
            cyc("to_fetch_wait", 0, 1, R, 0, 0, 0, 3'd1, 5'b10000, 6'b000000, 3'b000, 5);
        cyc("to_trap",  0, 1, R, 0, 0, 1, 3'd7, 5'b00000, 6'b000000, 3'b010, 5);
        cyc("to_idle",  0, 1, R, 0, 0, 0, 3'd0, 5'b00000, 6'b000000, 3'b000, 5);
        for (int i = 0; i < 3; i++)
            cyc("late_fetch_wait", 0, 1, ST, 0, 0, 0, 3'd1, 5'b10000, 6'b000000, 3'b000, 5);
        cyc("late_fetch_ack", 0, 1, ST, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 5);
        cyc("st_dec",   0, 1, ST, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 5);
        cyc("st_exe",   0, 1, ST, 0, 0, 0, 3'd3, 5'b00000, 6'b000100, 3'b000, 5);
        cyc("st_mem0",  0, 1, ST, 0, 0, 0, 3'd4, 5'b10010, 6'b000000, 3'b000, 5);
        for (int i = 0; i < 3; i++)
            cyc("st_stall", 0, 0, ST, 1, 0, 0, 3'd4, 5'b00000, 6'b000000, 3'b000, 5);
        cyc("st_mem_ack", 0, 1, ST, 1, 0, 0, 3'd4, 5'b10010, 6'b000000, 3'b001, 5);
        cyc("ld2_fetch",0, 1, LD, 1, 0, 0, 3'd1, 5'b11100, 6'b000000, 3'b000, 6);
        cyc("ld2_dec",  0, 1, LD, 0, 0, 0, 3'd2, 5'b00000, 6'b000000, 3'b000, 6);
        cyc("ld2_exe_stall", 0, 0, LD, 0, 0, 0, 3'd3, 5'b00000, 6'b000100, 3'b000, 6);
        cyc("ld2_exe",  0, 1, LD, 0, 0, 0, 3'd3, 5'b00000, 6'b000100, 3'b000, 6);
        cyc("ld2_mem",  0, 1, LD, 0, 0, 0, 3'd4, 5'b10000, 6'b000000, 3'b000, 6);
        cyc("async_rst",1, 1, LD, 0, 0, 0, 3'd0, 5'b00000, 6'b000000, 3'b000, 0);
        cyc("post_rst", 0, 0, LD, 0, 0, 0, 3'd0, 5'b00000, 6'b000000, 3'b000, 0);
        @(negedge CLK);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d vectors left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
